flash_page_sequencer: RTL and testbench
=======================================

Name: flash_page_sequencer

Overview:
- Job-level controller above `flash_state_machine`. It accepts one multi-page flash job (read or program) and expands it into a sequence of single-page macro commands (`FlashRdPg` / `FlashWrPg`).
- It steps the 32-bit address by one page per command, waits for `macro_states_done`, and reports progress, completion and timeout.
- Sits between the UART command decoder and `flash_state_machine`. It is the only driver of `macro_states` / `macro_states_valid`.

Parameters:
- PAGE_BYTES, 256, address increment per page command.
- TIMEOUT_CYCLES, 2000000, max cycles waiting for `macro_states_done` before abort.
- CNT_W, 16, width of page count and progress counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  job request; accepted when job_valid && job_ready
- job_ready  out  1  high only in S_IDLE
- job_op  in  1  0 = read pages (FlashRdPg), 1 = program pages (FlashWrPg)
- job_addr  in  32  start byte address, latched on accept
- job_pages  in  CNT_W  number of pages, latched on accept
- macro_states  out  4  macro code to flash_state_machine
- macro_states_valid  out  1  one-cycle issue strobe
- macro_states_done  in  1  page operation complete
- addr_out  out  64  {32'h0, current page address}
- busy  out  1  job in progress
- pages_done  out  CNT_W  pages completed in current/last job
- job_done  out  1  one-cycle pulse at normal completion
- job_err  out  1  sticky timeout flag; cleared on next job accept

Behaviour:
- Reset values: job_ready=0 during the reset cycle and 1 in S_IDLE after reset; macro_states=0; macro_states_valid=0; addr_out=0; busy=0; pages_done=0; job_done=0; job_err=0. Internal counters, state and latched job are cleared.
- Reset mid-job: the job is discarded immediately. No further strobes are issued and no done/err pulse is generated.
- States:
  - S_IDLE: on job accept, latch op/addr/pages, clear pages_done and job_err, set busy. If pages==0, go to S_DONE; else go to S_ISSUE (or S_PRE when the optional feature is enabled).
  - S_ISSUE: drive macro_states (0xD read / 0xC program) and addr_out; assert macro_states_valid for exactly 1 cycle; clear the timeout counter; go to S_WAIT.
  - S_WAIT:
    - macro_states_done is sampled only in this state; done seen in any other state is ignored.
    - On done: pages_done+1, addr += PAGE_BYTES (mod 2^32, wraps silently), remaining-1. If remaining becomes 0, go to S_DONE; else go to S_GAP.
    - Timeout counter reaching TIMEOUT_CYCLES-1 without done: set job_err, go to S_ABORT.
  - S_GAP: 1 idle cycle, then S_ISSUE. This lets flash_state_machine return to IDLE and drop its done flag.
  - S_DONE: job_done=1 for 1 cycle, busy=0, then S_IDLE.
  - S_ABORT: busy=0, no job_done, then S_IDLE.
- Handshake rules:
  - macro_states holds its value from the issue cycle until the next issue.
  - Only one macro is outstanding at a time; no new strobe is issued before done or timeout.
- Latency:
  - job accept to first strobe: 1 cycle.
  - done to next strobe: 2 cycles (WAIT→GAP→ISSUE).
  - final done to job_done: 1 cycle.
- job_valid while busy is ignored (job_ready=0); the job is not queued.
- macro_states_done asserted in the same cycle as the timeout expiry: done wins and the page counts as complete.

Optional Feature:
- Macro: FLASH_SEQ_PRE_STATUS_EN.
- Enabled: after accept (when pages≠0), enter S_PRE.
  - S_PRE issues FlashRdSR (0xE) once with a 1-cycle strobe, then enters S_PREW.
  - S_PREW waits for done under the same timeout; on done go to S_ISSUE; on timeout go to S_ABORT.
  - pages_done is not incremented for the status read.
- Disabled: S_PRE/S_PREW do not exist; accept goes straight to S_ISSUE.

Decomposition:
- Shared package `flash_pkg`:
  - macro codes (FlashRdID=0xB, FlashWrPg=0xC, FlashRdPg=0xD, FlashRdSR=0xE, FlashRdFR=0xF);
  - sequencer state encoding;
  - PAGE_BYTES default.
- flash_state_machine's macro code constants migrate to this package.
- One sub-module: `flash_timeout_cnt` (clear/enable/expire counter, width from TIMEOUT_CYCLES).

Test Plan:
- Program job addr=0x0000_1000, pages=3, model done 50 cycles after each strobe → 3 strobes of code 0xC at addresses 0x1000, 0x1100, 0x1200; strobes 52 cycles apart; pages_done=3; job_done one pulse.
- Read job addr=0xFFFF_FF00, pages=2 → strobe addresses 0xFFFF_FF00 then 0x0000_0000 (wrap); code 0xD; job_done pulses.
- pages=0 → no macros_valid ever; job_done pulses 1 cycle after accept; pages_done=0.
- TIMEOUT_CYCLES=100, model never answers → job_err=1 at exactly 100 cycles after the strobe; busy drops; no job_done; next accept clears job_err.
- rst asserted in S_WAIT of page 2 of 4 → next cycle all outputs at reset values; a later late done produces no strobe.
- With FLASH_SEQ_PRE_STATUS_EN, pages=1 → strobe 0xE, then after done strobe 0xC; pages_done=1.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared flash macro codes, sequencer state encoding and page size default.
// FLASH_SEQ_PRE_STATUS_EN adds the status-read pre-states S_PRE/S_PREW.
package flash_pkg;

    localparam logic [3:0] FlashRdID = 4'hB;
    localparam logic [3:0] FlashWrPg = 4'hC;
    localparam logic [3:0] FlashRdPg = 4'hD;
    localparam logic [3:0] FlashRdSR = 4'hE;
    localparam logic [3:0] FlashRdFR = 4'hF;

    localparam int PAGE_BYTES_DEF = 256;

`ifdef FLASH_SEQ_PRE_STATUS_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5,
        S_PRE   = 3'd6,
        S_PREW  = 3'd7
    } seq_state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } seq_state_e;
`endif

endpackage

// File: rtl/flash_page_sequencer_if.sv
// Job request / macro command bundle between host, sequencer and flash_state_machine.
interface flash_page_sequencer_if #(parameter int CNT_W = 16);

    logic             job_valid;
    logic             job_ready;
    logic             job_op;
    logic [31:0]      job_addr;
    logic [CNT_W-1:0] job_pages;
    logic [3:0]       macro_states;
    logic             macro_states_valid;
    logic             macro_states_done;
    logic [63:0]      addr_out;
    logic             busy;
    logic [CNT_W-1:0] pages_done;
    logic             job_done;
    logic             job_err;

    modport master (
        output job_valid, job_op, job_addr, job_pages, macro_states_done,
        input  job_ready, macro_states, macro_states_valid, addr_out,
               busy, pages_done, job_done, job_err
    );

    modport slave (
        input  job_valid, job_op, job_addr, job_pages, macro_states_done,
        output job_ready, macro_states, macro_states_valid, addr_out,
               busy, pages_done, job_done, job_err
    );

endinterface

// File: rtl/flash_timeout_cnt.sv
// Wait-for-done watchdog: restart on issue, count while waiting, flag expiry.
module flash_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [W-1:0] r_cnt;

    // The issue cycle counts as the first elapsed cycle, so expiry lands
    // exactly TIMEOUT_CYCLES cycles after the strobe.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= W'(1);
        else if (i_en && !o_expire)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expire = i_en && (r_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/flash_page_sequencer.sv
// Expands a multi-page read/program job into single-page flash macros.
// FLASH_SEQ_PRE_STATUS_EN: issue one FlashRdSR before the first page.
module flash_page_sequencer
    import flash_pkg::*;
#(
    parameter int PAGE_BYTES     = PAGE_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    flash_page_sequencer_if.slave  bus
);

    seq_state_e       r_state, w_next;
    logic             r_op;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] r_pages_done;
    logic             r_err;
    logic [3:0]       r_macro;

    logic             w_accept;
    logic             w_valid;
    logic [3:0]       w_code;
    logic             w_tmo_clr;
    logic             w_tmo_en;
    logic             w_expire;
    logic             w_page_done;
    logic             w_abort;
    logic             w_busy;
    logic             w_ready;

    flash_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_expire)
    );

    assign w_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept = bus.job_valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_valid     = 1'b0;
        w_code      = r_op ? FlashWrPg : FlashRdPg;
        w_tmo_clr   = 1'b0;
        w_tmo_en    = 1'b0;
        w_page_done = 1'b0;
        w_abort     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.job_pages == '0)
                        w_next = S_DONE;
                    else
`ifdef FLASH_SEQ_PRE_STATUS_EN
                        w_next = S_PRE;
`else
                        w_next = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                w_busy    = 1'b1;
                w_valid   = 1'b1;
                w_tmo_clr = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                w_busy   = 1'b1;
                w_tmo_en = 1'b1;
                // done beats a coincident expiry
                if (bus.macro_states_done) begin
                    w_page_done = 1'b1;
                    w_next      = (r_remain == CNT_W'(1)) ? S_DONE : S_GAP;
                end else if (w_expire) begin
                    w_abort = 1'b1;
                    w_next  = S_ABORT;
                end
            end
            S_GAP: begin
                w_busy = 1'b1;
                w_next = S_ISSUE;
            end
`ifdef FLASH_SEQ_PRE_STATUS_EN
            S_PRE: begin
                w_busy    = 1'b1;
                w_valid   = 1'b1;
                w_code    = FlashRdSR;
                w_tmo_clr = 1'b1;
                w_next    = S_PREW;
            end
            S_PREW: begin
                w_busy   = 1'b1;
                w_tmo_en = 1'b1;
                if (bus.macro_states_done) begin
                    w_next = S_ISSUE;
                end else if (w_expire) begin
                    w_abort = 1'b1;
                    w_next  = S_ABORT;
                end
            end
`endif
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= 1'b0;
            r_addr       <= '0;
            r_remain     <= '0;
            r_pages_done <= '0;
            r_err        <= 1'b0;
            r_macro      <= '0;
        end else begin
            if (w_accept) begin
                r_op         <= bus.job_op;
                r_addr       <= bus.job_addr;
                r_remain     <= bus.job_pages;
                r_pages_done <= '0;
                r_err        <= 1'b0;
            end
            if (w_valid)
                r_macro <= w_code;
            if (w_page_done) begin
                r_pages_done <= r_pages_done + 1'b1;
                r_addr       <= r_addr + 32'(PAGE_BYTES);
                r_remain     <= r_remain - 1'b1;
            end
            if (w_abort)
                r_err <= 1'b1;
        end
    end

    // Code is visible in the issue cycle itself and held until the next issue.
    assign bus.macro_states       = w_valid ? w_code : r_macro;
    assign bus.macro_states_valid = w_valid;
    assign bus.job_ready          = w_ready;
    assign bus.addr_out           = {32'h0, r_addr};
    assign bus.busy               = w_busy;
    assign bus.pages_done         = r_pages_done;
    assign bus.job_done           = (r_state == S_DONE);
    assign bus.job_err            = r_err;

endmodule

// File: tb/tb_flash_page_sequencer.sv
// Directed bench for flash_page_sequencer (TIMEOUT_CYCLES=100).
module tb_flash_page_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_strobe = 0;
    int   n_jdone = 0;

    flash_page_sequencer_if #(.CNT_W(16)) bus ();

    flash_page_sequencer #(
        .PAGE_BYTES     (256),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.macro_states_valid) n_strobe++;
        if (bus.job_done) n_jdone++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic accept(input logic op, input logic [31:0] addr, input logic [15:0] pages);
        bus.job_valid = 1'b1;
        bus.job_op    = op;
        bus.job_addr  = addr;
        bus.job_pages = pages;
        tick();
        bus.job_valid = 1'b0;
    endtask

    initial begin
        bus.job_valid         = 1'b0;
        bus.job_op            = 1'b0;
        bus.job_addr          = '0;
        bus.job_pages         = '0;
        bus.macro_states_done = 1'b0;

        // reset state
        ticks(2);
        chk("rst_ready", bus.job_ready, 0);
        chk("rst_valid", bus.macro_states_valid, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", bus.job_ready, 1);
        chk("idle_macro", bus.macro_states, 0);
        chk("idle_addr", bus.addr_out, 0);
        chk("idle_pgdone", bus.pages_done, 0);
        chk("idle_err", bus.job_err, 0);
        chk("idle_jdone", bus.job_done, 0);

`ifdef FLASH_SEQ_PRE_STATUS_EN
        // status read precedes the single program page
        accept(1'b1, 32'h0000_6000, 16'd1);
        chk("pre_valid", bus.macro_states_valid, 1);
        chk("pre_code", bus.macro_states, 4'hE);
        chk("pre_busy", bus.busy, 1);
        ticks(2);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        chk("pre_pg_valid", bus.macro_states_valid, 1);
        chk("pre_pg_code", bus.macro_states, 4'hC);
        chk("pre_pg_addr", bus.addr_out, 64'h6000);
        chk("pre_pgdone0", bus.pages_done, 0);
        ticks(2);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        chk("pre_jdone", bus.job_done, 1);
        chk("pre_pgdone1", bus.pages_done, 1);
`else
        // program job, 3 pages, done 50 cycles after each strobe
        n_jdone = 0;
        accept(1'b1, 32'h0000_1000, 16'd3);
        chk("pg_s0_valid", bus.macro_states_valid, 1);
        chk("pg_s0_code", bus.macro_states, 4'hC);
        chk("pg_s0_addr", bus.addr_out, 64'h1000);
        chk("pg_busy", bus.busy, 1);
        chk("pg_ready", bus.job_ready, 0);
        for (int p = 0; p < 2; p++) begin
            n_strobe = 0;
            ticks(50);
            bus.macro_states_done = 1'b1;
            tick();
            // on page 2 done stays high through the gap cycle and must not count twice
            if (p != 1) bus.macro_states_done = 1'b0;
            tick();
            bus.macro_states_done = 1'b0;
            chk("pg_spacing", n_strobe, 1);
            chk("pg_s_valid", bus.macro_states_valid, 1);
            chk("pg_s_code", bus.macro_states, 4'hC);
            chk("pg_s_addr", bus.addr_out, 64'h1000 + 64'(p + 1) * 64'h100);
            chk("pg_s_pgdone", bus.pages_done, p + 1);
        end
        ticks(50);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        chk("pg_jdone", bus.job_done, 1);
        chk("pg_busy_done", bus.busy, 0);
        chk("pg_pgdone3", bus.pages_done, 3);
        tick();
        chk("pg_jdone_pulse", n_jdone, 1);
        chk("pg_ready_after", bus.job_ready, 1);

        // read job across the 32-bit address wrap
        accept(1'b0, 32'hFFFF_FF00, 16'd2);
        chk("rd_s0_code", bus.macro_states, 4'hD);
        chk("rd_s0_addr", bus.addr_out, 64'hFFFF_FF00);
        ticks(3);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        tick();
        chk("rd_s1_valid", bus.macro_states_valid, 1);
        chk("rd_s1_code", bus.macro_states, 4'hD);
        chk("rd_s1_addr", bus.addr_out, 64'h0);
        ticks(3);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        chk("rd_jdone", bus.job_done, 1);
        chk("rd_pgdone", bus.pages_done, 2);
        tick();
        chk("rd_hold_code", bus.macro_states, 4'hD);
        chk("rd_jdone_low", bus.job_done, 0);

        // zero-page job
        n_strobe = 0;
        n_jdone = 0;
        accept(1'b1, 32'h0000_2000, 16'd0);
        chk("z_jdone", bus.job_done, 1);
        chk("z_busy", bus.busy, 0);
        chk("z_pgdone", bus.pages_done, 0);
        tick();
        chk("z_ready", bus.job_ready, 1);
        chk("z_no_strobe", n_strobe, 0);
        chk("z_one_pulse", n_jdone, 1);

        // timeout: no done ever
        n_jdone = 0;
        accept(1'b1, 32'h0000_3000, 16'd1);
        chk("to_valid", bus.macro_states_valid, 1);
        ticks(99);
        chk("to_err_early", bus.job_err, 0);
        chk("to_busy_early", bus.busy, 1);
        tick();
        chk("to_err", bus.job_err, 1);
        chk("to_busy", bus.busy, 0);
        tick();
        chk("to_err_sticky", bus.job_err, 1);
        chk("to_ready", bus.job_ready, 1);
        chk("to_no_jdone", n_jdone, 0);

        // accept clears job_err; done coincident with expiry wins
        accept(1'b0, 32'h0000_4000, 16'd1);
        chk("tie_err_clr", bus.job_err, 0);
        ticks(99);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        chk("tie_jdone", bus.job_done, 1);
        chk("tie_err", bus.job_err, 0);
        chk("tie_pgdone", bus.pages_done, 1);
        tick();

        // reset while waiting on page 2 of 4
        accept(1'b1, 32'h0000_5000, 16'd4);
        ticks(2);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        tick();
        chk("mr_s1_addr", bus.addr_out, 64'h5100);
        tick();
        rst = 1'b1;
        tick();
        chk("mr_ready", bus.job_ready, 0);
        chk("mr_valid", bus.macro_states_valid, 0);
        chk("mr_macro", bus.macro_states, 0);
        chk("mr_addr", bus.addr_out, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_pgdone", bus.pages_done, 0);
        chk("mr_err", bus.job_err, 0);
        chk("mr_jdone", bus.job_done, 0);
        rst = 1'b0;
        n_strobe = 0;
        n_jdone = 0;
        tick();
        chk("mr_ready_after", bus.job_ready, 1);
        bus.macro_states_done = 1'b1;
        tick();
        bus.macro_states_done = 1'b0;
        ticks(5);
        chk("mr_late_strobe", n_strobe, 0);
        chk("mr_late_jdone", n_jdone, 0);
        chk("mr_late_pgdone", bus.pages_done, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
